// File: rtl/fb_write_ctrl_if.sv
// rtl/fb_write_ctrl_if.sv - frame buffer write controller bus: clear control, draw handshake, buffer write port
interface fb_write_ctrl_if;
    logic        clear_start;
    logic [3:0]  clear_color;
    logic        clear_busy;
    logic        clear_done;
    logic        draw_valid;
    logic [9:0]  draw_x;
    logic [9:0]  draw_y;
    logic [3:0]  draw_color;
    logic        draw_ready;
    logic [19:0] fb_w_addr;
    logic [3:0]  fb_wdata;
    logic        fb_write;

    modport master (
        output clear_start, clear_color, draw_valid, draw_x, draw_y, draw_color,
        input  clear_busy, clear_done, draw_ready, fb_w_addr, fb_wdata, fb_write
    );

    modport slave (
        input  clear_start, clear_color, draw_valid, draw_x, draw_y, draw_color,
        output clear_busy, clear_done, draw_ready, fb_w_addr, fb_wdata, fb_write
    );
endinterface

// File: rtl/fb_write_ctrl.sv
// rtl/fb_write_ctrl.sv - frame buffer write port arbiter between pixel draws and a full-screen clear sweep
module fb_write_ctrl #(
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic           Clk,
    input  logic           Reset,
    fb_write_ctrl_if.slave bus
);
    localparam logic [31:0] H_RES_U = 32'(H_RES);
    localparam logic [31:0] V_RES_U = 32'(V_RES);
    localparam logic [20:0] PIX     = 21'(H_RES * V_RES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [20:0] cnt_q, cnt_d;
    logic [3:0]  color_q, color_d;
    logic        fb_write_q, fb_write_d;
    logic [19:0] fb_w_addr_q, fb_w_addr_d;
    logic [3:0]  fb_wdata_q, fb_wdata_d;
    logic        clear_busy_q, clear_busy_d;
    logic        clear_done_q, clear_done_d;
    logic        draw_ready;
    logic        on_screen;
    logic [31:0] lin_addr;

    assign draw_ready = (state_q == IDLE) && !bus.clear_start;
    assign lin_addr   = 32'(bus.draw_y) * H_RES_U + 32'(bus.draw_x);
    assign on_screen  = (32'(bus.draw_x) < H_RES_U) && (32'(bus.draw_y) < V_RES_U);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        color_d      = color_q;
        fb_write_d   = 1'b0;
        fb_w_addr_d  = fb_w_addr_q;
        fb_wdata_d   = fb_wdata_q;
        clear_busy_d = 1'b0;
        clear_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.clear_start) begin
                    // Address 0 is issued straight away so it appears in the first CLEAR cycle.
                    state_d      = CLEAR;
                    color_d      = bus.clear_color;
                    cnt_d        = 21'd1;
                    fb_write_d   = 1'b1;
                    fb_w_addr_d  = 20'd0;
                    fb_wdata_d   = bus.clear_color;
                    clear_busy_d = 1'b1;
                end else if (bus.draw_valid && on_screen) begin
                    fb_write_d  = 1'b1;
                    fb_w_addr_d = lin_addr[19:0];
                    fb_wdata_d  = bus.draw_color;
                end
            end
            CLEAR: begin
                if (cnt_q == PIX) begin
                    state_d      = DONE;
                    cnt_d        = 21'd0;
                    clear_done_d = 1'b1;
                end else begin
                    cnt_d        = cnt_q + 21'd1;
                    fb_write_d   = 1'b1;
                    fb_w_addr_d  = cnt_q[19:0];
                    fb_wdata_d   = color_q;
                    clear_busy_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            cnt_q        <= 21'd0;
            color_q      <= 4'd0;
            fb_write_q   <= 1'b0;
            fb_w_addr_q  <= 20'd0;
            fb_wdata_q   <= 4'd0;
            clear_busy_q <= 1'b0;
            clear_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            color_q      <= color_d;
            fb_write_q   <= fb_write_d;
            fb_w_addr_q  <= fb_w_addr_d;
            fb_wdata_q   <= fb_wdata_d;
            clear_busy_q <= clear_busy_d;
            clear_done_q <= clear_done_d;
        end
    end

    assign bus.draw_ready = draw_ready;
    assign bus.fb_write   = fb_write_q;
    assign bus.fb_w_addr  = fb_w_addr_q;
    assign bus.fb_wdata   = fb_wdata_q;
    assign bus.clear_busy = clear_busy_q;
    assign bus.clear_done = clear_done_q;
endmodule

// File: tb/tb_fb_write_ctrl.sv
// tb/tb_fb_write_ctrl.sv - directed bench for fb_write_ctrl at default and 8x4 resolutions
module tb_fb_write_ctrl;
    logic Clk;
    logic Reset;
    int   n_cmp;
    int   n_err;

    fb_write_ctrl_if ia ();
    fb_write_ctrl_if ib ();

    fb_write_ctrl u_dut_a (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (ia)
    );

    fb_write_ctrl #(.H_RES(8), .V_RES(4)) u_dut_b (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (ib)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_b_idle_out(input string tag);
        chk({tag, " fb_write"},   32'(ib.fb_write),   32'd0);
        chk({tag, " clear_busy"}, 32'(ib.clear_busy), 32'd0);
        chk({tag, " clear_done"}, 32'(ib.clear_done), 32'd0);
    endtask

    initial begin
        logic saw_bad;
        n_cmp = 0;
        n_err = 0;
        Reset = 1'b1;
        ia.clear_start = 0; ia.clear_color = 0; ia.draw_valid = 0;
        ia.draw_x = 0; ia.draw_y = 0; ia.draw_color = 0;
        ib.clear_start = 0; ib.clear_color = 0; ib.draw_valid = 0;
        ib.draw_x = 0; ib.draw_y = 0; ib.draw_color = 0;
        tick();
        tick();
        Reset = 1'b0;
        #1;
        chk("rst fb_write",   32'(ia.fb_write),   32'd0);
        chk("rst fb_w_addr",  32'(ia.fb_w_addr),  32'd0);
        chk("rst fb_wdata",   32'(ia.fb_wdata),   32'd0);
        chk("rst clear_busy", 32'(ia.clear_busy), 32'd0);
        chk("rst clear_done", 32'(ia.clear_done), 32'd0);
        chk("rst draw_ready", 32'(ia.draw_ready), 32'd1);

        // Single draw at default resolution: 2*640+5 = 1285
        ia.draw_valid = 1; ia.draw_x = 10'd5; ia.draw_y = 10'd2; ia.draw_color = 4'hA;
        #1 chk("draw1 ready", 32'(ia.draw_ready), 32'd1);
        tick();
        ia.draw_valid = 0;
        chk("draw1 write", 32'(ia.fb_write),  32'd1);
        chk("draw1 addr",  32'(ia.fb_w_addr), 32'd1285);
        chk("draw1 data",  32'(ia.fb_wdata),  32'hA);
        tick();
        chk("draw1 after", 32'(ia.fb_write), 32'd0);

        // Clear sweep on 8x4 with color change right after the start pulse
        ib.clear_start = 1; ib.clear_color = 4'h3;
        #1 chk("clr ready at start", 32'(ib.draw_ready), 32'd0);
        tick();
        ib.clear_start = 0; ib.clear_color = 4'h7;
        for (int k = 0; k < 32; k++) begin
            chk($sformatf("clr%0d write", k), 32'(ib.fb_write),   32'd1);
            chk($sformatf("clr%0d addr", k),  32'(ib.fb_w_addr),  32'(k));
            chk($sformatf("clr%0d data", k),  32'(ib.fb_wdata),   32'h3);
            chk($sformatf("clr%0d busy", k),  32'(ib.clear_busy), 32'd1);
            chk($sformatf("clr%0d ready", k), 32'(ib.draw_ready), 32'd0);
            tick();
        end
        chk("clr done write", 32'(ib.fb_write),   32'd0);
        chk("clr done busy",  32'(ib.clear_busy), 32'd0);
        chk("clr done pulse", 32'(ib.clear_done), 32'd1);
        chk("clr done ready", 32'(ib.draw_ready), 32'd0);
        tick();
        chk("clr idle done",  32'(ib.clear_done), 32'd0);
        chk("clr idle ready", 32'(ib.draw_ready), 32'd1);

        // clear_start together with a draw; draw is held and written after the sweep
        ib.clear_start = 1; ib.clear_color = 4'hC;
        ib.draw_valid = 1; ib.draw_x = 10'd1; ib.draw_y = 10'd1; ib.draw_color = 4'h5;
        #1 chk("sim ready", 32'(ib.draw_ready), 32'd0);
        tick();
        ib.clear_start = 0;
        for (int k = 0; k < 32; k++) begin
            ib.clear_start = (k == 10);
            #1;
            chk($sformatf("sim%0d addr", k),  32'(ib.fb_w_addr),  32'(k));
            chk($sformatf("sim%0d data", k),  32'(ib.fb_wdata),   32'hC);
            chk($sformatf("sim%0d ready", k), 32'(ib.draw_ready), 32'd0);
            tick();
        end
        ib.clear_start = 0;
        #1;
        chk("sim done pulse", 32'(ib.clear_done), 32'd1);
        chk("sim done ready", 32'(ib.draw_ready), 32'd0);
        tick();
        chk("sim idle ready", 32'(ib.draw_ready), 32'd1);
        tick();
        ib.draw_valid = 0;
        chk("sim draw write", 32'(ib.fb_write),   32'd1);
        chk("sim draw addr",  32'(ib.fb_w_addr),  32'd9);
        chk("sim draw data",  32'(ib.fb_wdata),   32'h5);
        chk("sim draw busy",  32'(ib.clear_busy), 32'd0);
        tick();
        chk_b_idle_out("sim no restart");

        // Off-screen and boundary draws, back to back
        ib.draw_valid = 1; ib.draw_x = 10'd8; ib.draw_y = 10'd0; ib.draw_color = 4'h1;
        #1 chk("off x ready", 32'(ib.draw_ready), 32'd1);
        tick();
        ib.draw_x = 10'd0; ib.draw_y = 10'd4; ib.draw_color = 4'h2;
        chk("off x nowrite", 32'(ib.fb_write), 32'd0);
        #1 chk("off y ready", 32'(ib.draw_ready), 32'd1);
        tick();
        ib.draw_x = 10'd7; ib.draw_y = 10'd3; ib.draw_color = 4'hF;
        chk("off y nowrite", 32'(ib.fb_write), 32'd0);
        #1 chk("corner ready", 32'(ib.draw_ready), 32'd1);
        tick();
        ib.draw_valid = 0;
        chk("corner write", 32'(ib.fb_write),  32'd1);
        chk("corner addr",  32'(ib.fb_w_addr), 32'd31);
        chk("corner data",  32'(ib.fb_wdata),  32'hF);
        tick();
        chk("corner after", 32'(ib.fb_write), 32'd0);

        // Three on-screen draws in consecutive cycles: (0,0) (1,0) (2,1) -> 0, 1, 10
        ib.draw_valid = 1; ib.draw_x = 10'd0; ib.draw_y = 10'd0; ib.draw_color = 4'h1;
        tick();
        ib.draw_x = 10'd1; ib.draw_y = 10'd0; ib.draw_color = 4'h2;
        chk("b2b0 write", 32'(ib.fb_write),  32'd1);
        chk("b2b0 addr",  32'(ib.fb_w_addr), 32'd0);
        chk("b2b0 data",  32'(ib.fb_wdata),  32'h1);
        tick();
        ib.draw_x = 10'd2; ib.draw_y = 10'd1; ib.draw_color = 4'h3;
        chk("b2b1 write", 32'(ib.fb_write),  32'd1);
        chk("b2b1 addr",  32'(ib.fb_w_addr), 32'd1);
        chk("b2b1 data",  32'(ib.fb_wdata),  32'h2);
        tick();
        ib.draw_valid = 0;
        chk("b2b2 write", 32'(ib.fb_write),  32'd1);
        chk("b2b2 addr",  32'(ib.fb_w_addr), 32'd10);
        chk("b2b2 data",  32'(ib.fb_wdata),  32'h3);
        tick();
        chk("b2b after", 32'(ib.fb_write), 32'd0);

        // Reset in the middle of a sweep
        ib.clear_start = 1; ib.clear_color = 4'h6;
        tick();
        ib.clear_start = 0;
        for (int k = 0; k < 10; k++) tick();
        chk("mid addr before rst", 32'(ib.fb_w_addr), 32'd10);
        Reset = 1;
        tick();
        Reset = 0;
        chk("mid rst write",  32'(ib.fb_write),   32'd0);
        chk("mid rst addr",   32'(ib.fb_w_addr),  32'd0);
        chk("mid rst data",   32'(ib.fb_wdata),   32'd0);
        chk("mid rst busy",   32'(ib.clear_busy), 32'd0);
        chk("mid rst done",   32'(ib.clear_done), 32'd0);
        #1 chk("mid rst ready", 32'(ib.draw_ready), 32'd1);
        saw_bad = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (ib.clear_done !== 1'b0 || ib.fb_write !== 1'b0) saw_bad = 1'b1;
        end
        chk("mid no done pulse", 32'(saw_bad), 32'd0);
        ib.clear_start = 1; ib.clear_color = 4'h9;
        tick();
        ib.clear_start = 0;
        chk("restart write", 32'(ib.fb_write),  32'd1);
        chk("restart addr0", 32'(ib.fb_w_addr), 32'd0);
        chk("restart data",  32'(ib.fb_wdata),  32'h9);
        tick();
        chk("restart addr1", 32'(ib.fb_w_addr), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fb_write_ctrl.md
# fb_write_ctrl

Write-port controller for the 4-bit-per-pixel 640x480 frame buffer. Shares the single buffer write port between two sources: a pixel-draw requester using a valid/ready handshake with (x, y, color), and an internal full-screen clear engine started by a pulse. It converts coordinates to linear addresses, drops off-screen pixels, and sequences the clear sweep at one pixel per clock. The read port of the buffer is not touched.

## Interface
- H_RES, default 640: pixels per line.
- V_RES, default 480: lines per frame. Total pixel count is H_RES*V_RES, which must be at most 2^20.
- Clk  in  1  system clock; all logic is on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- clear_start  in  1  one-cycle request to fill the whole buffer.
- clear_color  in  4  fill color, sampled when clear_start is accepted.
- clear_busy  out  1  high while the clear sweep is issuing writes.
- clear_done  out  1  one-cycle pulse after the last clear write.
- draw_valid  in  1  a draw request is present.
- draw_x  in  10  pixel column.
- draw_y  in  10  pixel row.
- draw_color  in  4  pixel color.
- draw_ready  out  1  controller accepts the request this cycle (combinational).
- fb_w_addr  out  20  buffer write address (registered).
- fb_wdata  out  4  buffer write data (registered).
- fb_write  out  1  buffer write enable (registered).

## Operation
- FSM states:
  - IDLE: draws are serviced.
  - CLEAR: the sweep runs.
  - DONE: a single cycle that pulses clear_done, then returns to IDLE.
- Transitions:
  - IDLE -> CLEAR on clear_start.
  - CLEAR -> DONE after the write to address H_RES*V_RES-1.
  - DONE -> IDLE unconditionally.
- draw_ready = (state == IDLE) && !clear_start. A clear_start wins over a simultaneous draw_valid, and that draw stays pending.
- Draw handshake: a transfer happens in any cycle with draw_valid && draw_ready.
  - The requester must hold x, y and color stable while valid is high and ready is low.
  - Each transfer produces at most one write.
- Address rule: fb_w_addr = draw_y*H_RES + draw_x, computed at full width and truncated to 20 bits. With the default H_RES this is (y<<9)+(y<<7)+x.
- Off-screen draws (x >= H_RES or y >= V_RES) are accepted (ready stays high) and produce no write: fb_write = 0.
- Clear sweep:
  - On entering CLEAR, clear_color is latched and an address counter starts at 0.
  - One write per cycle at addresses 0, 1, ..., H_RES*V_RES-1, all with the latched color.
  - A change on clear_color mid-sweep has no effect.
- clear_start is ignored while in CLEAR or DONE. No queueing, no restart.
- clear_busy = 1 exactly in the cycles where fb_write carries a clear write.
- Reset, including mid-sweep:
  - state goes to IDLE; fb_write, fb_w_addr, fb_wdata, clear_busy and clear_done are all 0.
  - The address counter is cleared.
  - No clear_done pulse is issued for an aborted sweep.
  - draw_ready is 1 in the first cycle after reset, provided clear_start is low.

## Timing
- Draw latency:
  - Handshake in cycle N gives fb_write = 1 with the address and data in cycle N+1.
  - Back-to-back handshakes give one write per cycle.
  - A registered output holds fb_write = 0 in any cycle that follows a cycle with no on-screen transfer.
- Clear, with clear_start accepted in cycle N and P = H_RES*V_RES:
  - Cycles N+1 .. N+P: fb_write = 1, address k in cycle N+1+k, clear_busy = 1, draw_ready = 0.
  - Cycle N+P+1 (state DONE): fb_write = 0, clear_busy = 0, clear_done = 1, draw_ready = 0.
  - Cycle N+P+2: state IDLE. draw_ready = 1; a draw accepted here writes in N+P+3.
- The full default sweep takes 307200 write cycles plus 1 done cycle.
- Throughput is one buffer write per clock, always. The controller never issues two writes in one cycle and never mixes clear and draw writes.

## Test plan
- Reset then single draw, defaults: x=5, y=2, color=0xA, valid for one cycle. Expected: ready=1, and the next cycle gives fb_write=1, addr=1285, data=0xA, followed by fb_write=0.
- Clear, with H_RES=8, V_RES=4: pulse clear_start with color 0x3, then change clear_color to 0x7 in the next cycle. Expected:
  - 32 consecutive writes, addresses 0..31, all data 0x3, clear_busy high for exactly those 32 cycles.
  - Then one clear_done pulse, then draw_ready=1 one cycle later.
- Simultaneous events: clear_start together with draw_valid (x=1, y=1). Expected:
  - ready=0 in that cycle and throughout the sweep and DONE.
  - The held draw is accepted in the first IDLE cycle and written after the clear, to address 9 with H_RES=8.
  - A second clear_start mid-sweep changes nothing.
- Off-screen and boundary: draws at (8,0), (0,4), (7,3) with H_RES=8, V_RES=4. Expected: the first two are accepted with no write; the last writes address 31. Back-to-back valid for 3 cycles gives 3 consecutive handshakes.
- Reset mid-clear: assert Reset at sweep address 10 for 1 cycle. Expected:
  - All outputs are 0 the next cycle.
  - No clear_done pulse appears.
  - A new clear_start afterwards restarts the sweep from address 0.
